// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one DATA_BITS word per valid/ready handshake into an
// LSB-first frame (start, data, STOP_BITS stop) at BaudPeriod = CLOCK_RATE/BAUD_RATE cycles per bit.
package definitions_pkg;
  localparam int CLOCK_RATE = 18_432_000;
  localparam int BAUD_RATE  = 115_200;
endpackage

module uart_transmitter #(
  parameter int CLOCK_RATE = definitions_pkg::CLOCK_RATE,
  parameter int BAUD_RATE  = definitions_pkg::BAUD_RATE,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 baud,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BAUD_PERIOD = CLOCK_RATE / BAUD_RATE;
  localparam int CW = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
  localparam int IW = 4;

  localparam logic [CW-1:0] CNT_RELOAD = CW'(BAUD_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDX_ONE    = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] DATA_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST  = IW'(STOP_BITS - 1);

  if ((CLOCK_RATE % BAUD_RATE) != 0) begin : g_bad_ratio
    $fatal(1, "uart_transmitter: CLOCK_RATE must be a multiple of BAUD_RATE");
  end
  if (BAUD_PERIOD < 8) begin : g_bad_period
    $fatal(1, "uart_transmitter: baud period below 8 clock cycles");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $fatal(1, "uart_transmitter: DATA_BITS must be 5..9");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $fatal(1, "uart_transmitter: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [IW-1:0]        idx_r, idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 tx_r, tx_s;
  logic                 baud_r, baud_s;
  logic                 done_r, done_s;
  logic                 bit_end_s;
  logic                 new_bit_s;

  // A bit ends when the down-counter reaches zero; a new bit starts on handshake or
  // on any bit end that does not return to IDLE.
  assign bit_end_s = (cnt_r == {CW{1'b0}});
  assign new_bit_s = (state_r == S_IDLE) ? (state_s == S_START)
                                         : (bit_end_s && (state_s != S_IDLE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (tx_valid) state_s = S_START;
        else          state_s = S_IDLE;
      end
      S_START: begin
        if (bit_end_s) state_s = S_DATA;
        else           state_s = S_START;
      end
      S_DATA: begin
        if (bit_end_s && (idx_r == DATA_LAST)) state_s = S_STOP;
        else                                   state_s = S_DATA;
      end
      S_STOP: begin
        if (bit_end_s && (idx_r == STOP_LAST)) state_s = S_IDLE;
        else                                   state_s = S_STOP;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of datapath and registered pad outputs
  always_comb begin
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    tx_s    = 1'b1;
    baud_s  = new_bit_s;
    done_s  = (state_r == S_STOP) && (idx_r == STOP_LAST) && (cnt_r == CNT_ONE);

    if (new_bit_s)                cnt_s = CNT_RELOAD;
    else if (state_s != S_IDLE)   cnt_s = cnt_r - CNT_ONE;
    else                          cnt_s = {CW{1'b0}};

    if (state_s != state_r)                    idx_s = {IW{1'b0}};
    else if (bit_end_s && (state_r != S_IDLE)) idx_s = idx_r + IDX_ONE;
    else                                       idx_s = idx_r;

    if ((state_r == S_IDLE) && (state_s == S_START)) shift_s = tx_data;
    else if ((state_r == S_DATA) && bit_end_s)       shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
    else                                             shift_s = shift_r;

    // Line level follows the state being entered so the pad changes with baud.
    case (state_s)
      S_IDLE:  tx_s = 1'b1;
      S_START: tx_s = 1'b0;
      S_DATA:  tx_s = shift_s[0];
      S_STOP:  tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CW{1'b0}};
      idx_r   <= {IW{1'b0}};
      shift_r <= {DATA_BITS{1'b0}};
      tx_r    <= 1'b1;
      baud_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      baud_r  <= baud_s;
      done_r  <= done_s;
    end
  end

  assign tx       = tx_r;
  assign baud     = baud_r;
  assign tx_done  = done_r;
  assign tx_ready = (state_r == S_IDLE);
  assign busy     = (state_r != S_IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: two instances (8N1 and 7-bit/2-stop) at 8 cycles per bit,
// frames checked cycle by cycle against a per-bit reference waveform.
module tb_uart_transmitter;

  localparam int BP = 8;

  typedef struct {
    logic [8:0] w;
    bit         b2b;
  } frame_t;

  bit         clk = 1'b0;
  logic       rst_n;
  logic [7:0] data0;
  logic [6:0] data1;
  logic       valid0, valid1;
  logic [1:0] tx_v, baud_v, busy_v, done_v, ready_v;

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     last_done [2];
  frame_t q0 [$];
  frame_t q1 [$];

  uart_transmitter #(.CLOCK_RATE(80), .BAUD_RATE(10), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(data0), .tx_valid(valid0), .tx_ready(ready_v[0]),
    .tx(tx_v[0]), .baud(baud_v[0]), .busy(busy_v[0]), .tx_done(done_v[0])
  );

  uart_transmitter #(.CLOCK_RATE(80), .BAUD_RATE(10), .DATA_BITS(7), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data1), .tx_valid(valid1), .tx_ready(ready_v[1]),
    .tx(tx_v[1]), .baud(baud_v[1]), .busy(busy_v[1]), .tx_done(done_v[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int id, input logic [8:0] w, input bit b2b);
    frame_t f;
    f.w = w;
    f.b2b = b2b;
    if (id == 0) q0.push_back(f);
    else         q1.push_back(f);
  endtask

  task automatic drive(input int id, input logic [8:0] w, input logic v);
    if (id == 0) begin
      data0 = w[7:0];
      valid0 = v;
    end else begin
      data1 = w[6:0];
      valid1 = v;
    end
  endtask

  // Waits (bounded) at negedges until the given instance reports ready.
  task automatic wait_ready(input int id, input string name);
    int n = 0;
    while (ready_v[id] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 300), 32'd1);
  endtask

  task automatic send(input int id, input logic [8:0] w);
    @(negedge clk);
    drive(id, w, 1'b1);
    push(id, w, 1'b0);
    wait_ready(id, "accept_timeout");
    @(negedge clk);
    drive(id, w, 1'b0);
  endtask

  // Monitor: each frame start (line low outside a frame) pops the expected word and the
  // whole frame is compared against the ideal bit waveform.
  task automatic mon(input int id);
    int     db, sb, flen, k, start;
    int     be, ue, de, ye;
    logic [8:0] w, dec;
    logic   exp_bit;
    frame_t f;
    bit     aborted, have;
    db = (id == 0) ? 8 : 7;
    sb = (id == 0) ? 1 : 2;
    flen = (1 + db + sb) * BP;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) continue;
      if (tx_v[id] === 1'b1) begin
        chk($sformatf("idle_pulse%0d", id), {30'd0, baud_v[id], done_v[id]}, 32'd0);
        continue;
      end
      have = (id == 0) ? (q0.size() > 0) : (q1.size() > 0);
      chk($sformatf("unexpected_frame%0d", id), 32'(have), 32'd1);
      if (!have) f.w = 9'd0;
      else if (id == 0) f = q0.pop_front();
      else f = q1.pop_front();
      w = f.w;
      start = cyc;
      be = 0; ue = 0; de = 0; ye = 0; dec = 9'd0; aborted = 1'b0;
      for (int c = 0; c < flen; c++) begin
        if (c > 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        k = c / BP;
        if (k == 0)       exp_bit = 1'b0;
        else if (k <= db) exp_bit = w[k-1];
        else              exp_bit = 1'b1;
        if (tx_v[id] !== exp_bit) be++;
        if (baud_v[id] !== ((c % BP) == 0)) ue++;
        if (done_v[id] !== (c == flen - 1)) de++;
        if (busy_v[id] !== 1'b1) ye++;
        if (k >= 1 && k <= db && (c % BP) == BP / 2) dec[k-1] = tx_v[id];
      end
      if (!aborted) begin
        chk($sformatf("frame_bits%0d", id), be, 32'd0);
        chk($sformatf("baud_pulses%0d", id), ue, 32'd0);
        chk($sformatf("tx_done_pos%0d", id), de, 32'd0);
        chk($sformatf("busy_in_frame%0d", id), ye, 32'd0);
        chk($sformatf("decoded_word%0d", id), 32'(dec), 32'(w));
        if (f.b2b) chk($sformatf("b2b_gap%0d", id), start - last_done[id], 32'd2);
        last_done[id] = cyc;
      end
    end
  endtask

  initial fork
    mon(0);
    mon(1);
  join_none

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a, cnt_b;
    rst_n = 1'b0;
    data0 = 8'd0; data1 = 7'd0; valid0 = 1'b0; valid1 = 1'b0;

    // Reset values and idle behaviour
    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'd0, tx_v, ready_v, busy_v[0]}, {27'd0, 2'b11, 2'b11, 1'b0});
    chk("reset_pulses", {28'd0, baud_v, done_v}, 32'd0);
    rst_n = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_v !== 2'b11 || ready_v !== 2'b11 || busy_v !== 2'b00) cnt_a++;
    end
    chk("idle_20", cnt_a, 32'd0);

    // Single 0x55 frame
    send(0, 9'h055);
    wait_ready(0, "idle_after_55");

    // Back-to-back with held valid
    @(negedge clk);
    drive(0, 9'h0A5, 1'b1);
    push(0, 9'h0A5, 1'b0);
    wait_ready(0, "accept_a5");
    @(negedge clk);
    drive(0, 9'h03C, 1'b1);
    push(0, 9'h03C, 1'b1);
    wait_ready(0, "accept_3c");
    @(negedge clk);
    drive(0, 9'h03C, 1'b0);
    wait_ready(0, "idle_after_b2b");

    // Inputs disturbed mid-frame: only the latched word appears
    @(negedge clk);
    drive(0, 9'h0C3, 1'b1);
    push(0, 9'h0C3, 1'b0);
    wait_ready(0, "accept_c3");
    @(negedge clk);
    cnt_b = 0;
    for (int c = 1; c < 80; c++) begin
      if (ready_v[0] !== 1'b0) cnt_b++;
      if (c < 60) drive(0, 9'($urandom), 1'($urandom));
      else        drive(0, 9'h000, 1'b0);
      @(negedge clk);
    end
    chk("ready_low_in_frame", cnt_b, 32'd0);
    wait_ready(0, "idle_after_c3");

    // Reset in the middle of a 0x00 frame
    send(0, 9'h000);
    repeat (34) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_tx", {29'd0, tx_v[0], ready_v[0], busy_v[0]}, {29'd0, 3'b110});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1) cnt_a++;
    end
    chk("post_reset_idle", cnt_a, 32'd0);

    // Randomised frames with random gaps
    for (int i = 0; i < 6; i++) begin
      send(0, 9'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    wait_ready(0, "idle_after_random");
    repeat (85) @(negedge clk);

    // 7 data bits, 2 stop bits
    send(1, 9'h07F);
    for (int i = 0; i < 3; i++) send(1, 9'($urandom_range(0, 127)));
    wait_ready(1, "idle_after_7n2");
    repeat (90) @(negedge clk);

    chk("pending0", q0.size(), 32'd0);
    chk("pending1", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
